// File: rtl/axi_lite_master_seq.sv
// AXI4-Lite master sequencer: queues single-beat read/write commands, runs them in order, returns one response each.
// Optional read-compare checking is built when AXI_LITE_MASTER_SEQ_CMP_EN is defined.
module axi_lite_master_seq #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int CMD_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rd,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_strb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          rsp_cmp_err,
  output logic                          busy,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t state;

  logic                        fifo_rd    [CMD_DEPTH];
  logic [C_AXI_ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
  logic [C_AXI_DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
  logic [STRB_W-1:0]           fifo_strb  [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             push, pop;

  logic                        act_rd;
  logic [C_AXI_ADDR_WIDTH-1:0] act_addr;
  logic [C_AXI_DATA_WIDTH-1:0] act_wdata;
  logic [STRB_W-1:0]           act_strb;
  logic [TMR_W-1:0]            timer;
  logic                        aw_done, w_done;
  logic                        aw_hs, w_hs, tmr_expired;

`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
  logic [15:0] err_count;
`endif

  // A finished response may hand straight over to the next queued command
  assign push        = cmd_valid && cmd_ready;
  assign pop         = ((state == IDLE) || (state == RSP && rsp_ready)) && (count != '0);
  assign aw_hs       = m_axi_awvalid && m_axi_awready;
  assign w_hs        = m_axi_wvalid && m_axi_wready;
  assign tmr_expired = (timer == TMR_LAST);

  assign busy         = (count != '0) || (state != IDLE);
  assign m_axi_awaddr = act_addr;
  assign m_axi_araddr = act_addr;
  assign m_axi_wdata  = act_wdata;
  assign m_axi_wstrb  = act_strb;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W + 1)'(1);
      2'b01:   count_next = count - (PTR_W + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      fifo_rd[wr_ptr]    <= cmd_rd;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
      fifo_strb[wr_ptr]  <= cmd_strb;
    end
  end

  // cmd_ready is registered from the next occupancy so it never sees cmd_valid combinationally
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      cmd_ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state         <= IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
      act_rd        <= 1'b0;
      act_addr      <= '0;
      act_wdata     <= '0;
      act_strb      <= '0;
      timer         <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
      rsp_cmp_err   <= 1'b0;
      err_count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: ;
        WR_REQ: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            timer        <= '0;
            state        <= WR_RESP;
          end else if (tmr_expired) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_resp      <= 2'b10;
            rsp_rdata     <= '0;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
            rsp_cmp_err   <= 1'b0;
`endif
            state         <= RSP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
            rsp_cmp_err  <= 1'b0;
`endif
            state        <= RSP;
          end else if (tmr_expired) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_resp     <= 2'b10;
            rsp_rdata    <= '0;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
            rsp_cmp_err  <= 1'b0;
`endif
            state        <= RSP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            timer         <= '0;
            state         <= RD_DATA;
          end else if (tmr_expired) begin
            m_axi_arvalid <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_resp      <= 2'b10;
            rsp_rdata     <= '0;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
            rsp_cmp_err   <= 1'b0;
`endif
            state         <= RSP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= 1'b0;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
            // act_wdata carries the expected value for reads
            rsp_cmp_err  <= (m_axi_rdata != act_wdata);
            if ((m_axi_rdata != act_wdata) && (err_count != 16'hFFFF))
              err_count <= err_count + 16'd1;
`endif
            state        <= RSP;
          end else if (tmr_expired) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_resp     <= 2'b10;
            rsp_rdata    <= '0;
`ifdef AXI_LITE_MASTER_SEQ_CMP_EN
            rsp_cmp_err  <= 1'b0;
`endif
            state        <= RSP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Loading a new command overrides the IDLE transition taken above
      if (pop) begin
        act_rd    <= fifo_rd[rd_ptr];
        act_addr  <= fifo_addr[rd_ptr];
        act_wdata <= fifo_wdata[rd_ptr];
        act_strb  <= fifo_strb[rd_ptr];
        timer     <= '0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        if (fifo_rd[rd_ptr]) begin
          m_axi_arvalid <= 1'b1;
          state         <= RD_REQ;
        end else begin
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          state         <= WR_REQ;
        end
      end
    end
  end

`ifndef AXI_LITE_MASTER_SEQ_CMP_EN
  assign rsp_cmp_err = 1'b0;
`endif

endmodule
